// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
//   Writable sprite colour lookup. Converts a per-pixel palette index into
//   12-bit {R,G,B} through one of NUM_PAL run-time rewritable palettes, with
//   frame-synchronous colour cycling over [CYCLE_LO..CYCLE_HI], a saturating
//   per-request fade and a transparency flag for raw index 0.
//   Two-stage pipeline, one request per cycle, no back-pressure.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   valid_in              lookup request this cycle
//   pal_sel, index, fade  palette, pixel index and darkening for the request
//   wr_en, wr_pal,
//   wr_addr, wr_data      palette entry write port
//   frame_tick, cycle_en  per-frame pulse and colour-cycling enable
//   valid_out             result valid (2 cycles after valid_in)
//   red, green, blue      result colour, zero while valid_out is low
//   transparent           result came from raw index 0
module sprite_palette_bank #(
    parameter int          INDEX_W   = 4,
    parameter int          NUM_PAL   = 4,
    parameter int          PAL_W     = 2,
    parameter int          CYCLE_LO  = 8,
    parameter int          CYCLE_HI  = 11,
    parameter int          CYCLE_DIV = 8,
    parameter logic [11:0] BG_COLOR  = 12'h99F
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               valid_in,
    input  logic [PAL_W-1:0]   pal_sel,
    input  logic [INDEX_W-1:0] index,
    input  logic [3:0]         fade,
    input  logic               wr_en,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic [11:0]        wr_data,
    input  logic               frame_tick,
    input  logic               cycle_en,
    output logic               valid_out,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               transparent
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam int LEN   = CYCLE_HI - CYCLE_LO + 1;
    localparam int DIV_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;

    localparam logic [INDEX_W:0]   LO_C     = (INDEX_W + 1)'(CYCLE_LO);
    localparam logic [INDEX_W:0]   HI_C     = (INDEX_W + 1)'(CYCLE_HI);
    localparam logic [INDEX_W:0]   LEN_C    = (INDEX_W + 1)'(LEN);
    localparam logic [INDEX_W-1:0] ROT_MAX  = INDEX_W'(LEN - 1);
    localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(CYCLE_DIV - 1);
    localparam logic [PAL_W:0]     NPAL_C   = (PAL_W + 1)'(NUM_PAL);

    // Saturating channel darkening: max(ch - amt, 0).
    function automatic logic [3:0] sat_sub(input logic [3:0] ch, input logic [3:0] amt);
        logic [3:0] res;
        if (ch > amt) begin
            res = ch - amt;
        end else begin
            res = 4'd0;
        end
        return res;
    endfunction

    logic [11:0]        pal_mem_r [NUM_PAL][DEPTH];
    logic [DIV_W-1:0]   div_r;
    logic [INDEX_W-1:0] rot_r;

    logic               s1_valid_r;
    logic [PAL_W-1:0]   s1_pal_r;
    logic [INDEX_W-1:0] s1_eff_r;
    logic [3:0]         s1_fade_r;
    logic               s1_transp_r;

    logic               in_cyc_s;
    logic [INDEX_W:0]   offs_s;
    logic [INDEX_W:0]   wrap_s;
    logic [INDEX_W-1:0] eff_s;
    logic [11:0]        rd_s;

    // Palette storage: every entry returns to the background colour on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    pal_mem_r[p][a] <= BG_COLOR;
                end
            end
        end else if (wr_en && ({1'b0, wr_pal} < NPAL_C)) begin
            pal_mem_r[wr_pal][wr_addr] <= wr_data;
        end
    end

    // Colour-cycle divider and rotation; disabling cycling parks both at 0,
    // which also swallows a tick arriving in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_r <= '0;
            rot_r <= '0;
        end else if (!cycle_en) begin
            div_r <= '0;
            rot_r <= '0;
        end else if (frame_tick) begin
            if (div_r == DIV_MAX) begin
                div_r <= '0;
                rot_r <= (rot_r == ROT_MAX) ? '0 : rot_r + 1'b1;
            end else begin
                div_r <= div_r + 1'b1;
            end
        end
    end

    // Effective index: rotate inside the cycle range by the current offset.
    // index-LO and rot are both below LEN, so one conditional subtract wraps.
    always_comb begin
        in_cyc_s = ({1'b0, index} >= LO_C) && ({1'b0, index} <= HI_C);
        offs_s   = {1'b0, index} - LO_C + {1'b0, rot_r};
        if (offs_s >= LEN_C) begin
            wrap_s = offs_s - LEN_C;
        end else begin
            wrap_s = offs_s;
        end
        if (in_cyc_s) begin
            eff_s = INDEX_W'(LO_C + wrap_s);
        end else begin
            eff_s = index;
        end
    end

    // Stage 1: capture the request with the rotation in force this cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_pal_r    <= '0;
            s1_eff_r    <= '0;
            s1_fade_r   <= 4'd0;
            s1_transp_r <= 1'b0;
        end else begin
            s1_valid_r <= valid_in;
            if (valid_in) begin
                s1_pal_r    <= pal_sel;
                s1_eff_r    <= eff_s;
                s1_fade_r   <= fade;
                s1_transp_r <= (index == '0);
            end
        end
    end

    // Stage 2 read; a write landing on the same edge is seen one cycle later.
    always_comb begin
        if ({1'b0, s1_pal_r} < NPAL_C) begin
            rd_s = pal_mem_r[s1_pal_r][s1_eff_r];
        end else begin
            rd_s = BG_COLOR;
        end
    end

    // Stage 2 output register: faded colour, or blanking when idle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_out   <= 1'b0;
            red         <= 4'd0;
            green       <= 4'd0;
            blue        <= 4'd0;
            transparent <= 1'b0;
        end else if (s1_valid_r) begin
            valid_out   <= 1'b1;
            red         <= sat_sub(rd_s[11:8], s1_fade_r);
            green       <= sat_sub(rd_s[7:4],  s1_fade_r);
            blue        <= sat_sub(rd_s[3:0],  s1_fade_r);
            transparent <= s1_transp_r;
        end else begin
            valid_out   <= 1'b0;
            red         <= 4'd0;
            green       <= 4'd0;
            blue        <= 4'd0;
            transparent <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed testbench for sprite_palette_bank with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        valid_in;
    logic [1:0]  pal_sel;
    logic [3:0]  index;
    logic [3:0]  fade;
    logic        wr_en;
    logic [1:0]  wr_pal;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_tick;
    logic        cycle_en;
    logic        valid_out;
    logic [3:0]  red, green, blue;
    logic        transparent;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .valid_in(valid_in), .pal_sel(pal_sel),
        .index(index), .fade(fade), .wr_en(wr_en), .wr_pal(wr_pal),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_tick(frame_tick),
        .cycle_en(cycle_en), .valid_out(valid_out), .red(red), .green(green),
        .blue(blue), .transparent(transparent)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the whole output bundle {valid, transparent, rgb}.
    task automatic check_out(input string tag, input logic v, input logic t, input logic [11:0] rgb);
        check_eq(tag, {2'b00, valid_out, transparent, red, green, blue}, {2'b00, v, t, rgb});
    endtask

    task automatic wr(input logic [1:0] p, input logic [3:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_pal = p; wr_addr = a; wr_data = d;
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    // One request, then check the result two edges later.
    task automatic lookup(input string tag, input logic [1:0] p, input logic [3:0] i,
                          input logic [3:0] f, input logic [11:0] rgb);
        valid_in = 1'b1; pal_sel = p; index = i; fade = f;
        @(negedge Clk);
        valid_in = 1'b0;
        @(negedge Clk);
        check_out(tag, 1'b1, (i == 4'd0), rgb);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            @(negedge Clk);
        end
    endtask

    // Palette 0 contents after the cycling and collision writes (rot = 0).
    function automatic logic [11:0] pal0_exp(input int i);
        logic [11:0] v;
        case (i)
            6:       v = 12'hE92;
            8:       v = 12'h100;
            9:       v = 12'h200;
            10:      v = 12'h300;
            11:      v = 12'h400;
            default: v = 12'h99F;
        endcase
        return v;
    endfunction

    initial begin
        Reset_n = 1'b0; valid_in = 1'b0; pal_sel = 2'd0; index = 4'd0; fade = 4'd0;
        wr_en = 1'b0; wr_pal = 2'd0; wr_addr = 4'd0; wr_data = 12'h000;
        frame_tick = 1'b0; cycle_en = 1'b0;
        repeat (3) @(negedge Clk);
        check_out("reset_outputs", 1'b0, 1'b0, 12'h000);
        Reset_n = 1'b1;
        @(negedge Clk);

        lookup("reset_bg", 2'd0, 4'd5, 4'd0, 12'h99F);

        wr(2'd2, 4'd3, 12'hB32);
        lookup("wr_fade0", 2'd2, 4'd3, 4'd0, 12'hB32);
        lookup("wr_fade4", 2'd2, 4'd3, 4'd4, 12'h700);
        lookup("fade_f", 2'd2, 4'd3, 4'd15, 12'h000);

        lookup("transp_idx0", 2'd1, 4'd0, 4'd0, 12'h99F);
        @(negedge Clk);
        check_out("blanking", 1'b0, 1'b0, 12'h000);

        wr(2'd0, 4'd8, 12'h100);
        wr(2'd0, 4'd9, 12'h200);
        wr(2'd0, 4'd10, 12'h300);
        wr(2'd0, 4'd11, 12'h400);
        cycle_en = 1'b1;
        ticks(7);
        // 8th tick and a request in the same cycle: request sees old rot.
        frame_tick = 1'b1; valid_in = 1'b1; pal_sel = 2'd0; index = 4'd8; fade = 4'd0;
        @(negedge Clk);
        frame_tick = 1'b0; valid_in = 1'b0;
        @(negedge Clk);
        check_out("rot_same_cycle", 1'b1, 1'b0, 12'h100);
        lookup("cyc_rot1_idx8", 2'd0, 4'd8, 4'd0, 12'h200);
        lookup("cyc_rot1_idx11", 2'd0, 4'd11, 4'd0, 12'h100);
        lookup("cyc_outside", 2'd0, 4'd7, 4'd0, 12'h99F);
        ticks(24);
        lookup("cyc_wrap", 2'd0, 4'd8, 4'd0, 12'h100);
        ticks(8);
        lookup("cyc_rot1_idx9", 2'd0, 4'd9, 4'd0, 12'h300);
        cycle_en = 1'b0; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        lookup("cyc_disabled", 2'd0, 4'd8, 4'd0, 12'h100);

        // Collision: write lands on the same edge as the stage-2 read.
        valid_in = 1'b1; pal_sel = 2'd0; index = 4'd6; fade = 4'd0;
        @(negedge Clk);
        valid_in = 1'b0;
        wr_en = 1'b1; wr_pal = 2'd0; wr_addr = 4'd6; wr_data = 12'hE92;
        @(negedge Clk);
        wr_en = 1'b0;
        check_out("collision_old", 1'b1, 1'b0, 12'h99F);
        lookup("collision_new", 2'd0, 4'd6, 4'd0, 12'hE92);

        // Back-to-back: 16 requests, results in order two cycles later.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                valid_in = 1'b1; pal_sel = 2'd0; index = 4'(k); fade = 4'd0;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge Clk);
            if (k == 0) begin
                check_out("b2b_not_early", 1'b0, 1'b0, 12'h000);
            end else begin
                check_out($sformatf("b2b_%0d", k - 1), 1'b1, (k == 1), pal0_exp(k - 1));
            end
        end
        @(negedge Clk);
        check_out("b2b_end", 1'b0, 1'b0, 12'h000);

        // Asynchronous reset mid-pipeline.
        valid_in = 1'b1; pal_sel = 2'd2; index = 4'd3; fade = 4'd0;
        @(negedge Clk);
        index = 4'd4;
        @(negedge Clk);
        valid_in = 1'b0;
        check_out("pre_reset", 1'b1, 1'b0, 12'hB32);
        #2 Reset_n = 1'b0;
        #1 check_out("async_drop", 1'b0, 1'b0, 12'h000);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_out("inflight_lost", 1'b0, 1'b0, 12'h000);
        lookup("pal_reverted", 2'd2, 4'd3, 4'd0, 12'h99F);
        lookup("pal0_reverted", 2'd0, 4'd6, 4'd0, 12'h99F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Parametrised, writable sprite colour-lookup block that turns a per-pixel palette index into 12-bit RGB for the VGA colour mapper. It holds several selectable palettes in register storage that can be rewritten at run time. It adds frame-synchronous colour cycling over an index range, a saturating fade, and a transparency flag for index 0. It sits between the sprite ROM index output and the colour mapper. Lookups run in a 2-stage pipeline with valid tracking.

## Interface
Parameters:
- INDEX_W, 4, palette index width; each palette has 2^INDEX_W entries
- NUM_PAL, 4, number of palettes; must be ≥2
- PAL_W, 2, palette-select width, equal to clog2(NUM_PAL)
- CYCLE_LO, 8, first entry of the colour-cycle range
- CYCLE_HI, 11, last entry of the colour-cycle range; requires CYCLE_LO < CYCLE_HI < 2^INDEX_W
- CYCLE_DIV, 8, frame_tick pulses per cycle step; must be ≥1
- BG_COLOR, 12'h99F, reset value of every entry, as {R,G,B}

Ports:
- Clk, in, 1, sole clock
- Reset_n, in, 1, asynchronous, active-low reset
- valid_in, in, 1, lookup request this cycle
- pal_sel, in, PAL_W, palette for the request
- index, in, INDEX_W, pixel index for the request
- fade, in, 4, darkening amount, sampled with the request
- wr_en, in, 1, palette write strobe
- wr_pal, in, PAL_W, palette to write
- wr_addr, in, INDEX_W, entry to write
- wr_data, in, 12, {R,G,B} to write
- frame_tick, in, 1, one-cycle pulse per frame (vsync edge)
- cycle_en, in, 1, enables colour cycling
- valid_out, out, 1, result valid
- red, out, 4, red result
- green, out, 4, green result
- blue, out, 4, blue result
- transparent, out, 1, result came from raw index 0

## Operation
- Storage: NUM_PAL × 2^INDEX_W × 12-bit registers. On Reset_n low, every entry is set to BG_COLOR.
- Write: when wr_en is high at a Clk edge, entry [wr_pal][wr_addr] takes wr_data. Out-of-range wr_pal (≥NUM_PAL) is ignored.
- Cycling: the divider counter div (0..CYCLE_DIV-1) counts frame_tick pulses while cycle_en=1.
  - On a tick with div=CYCLE_DIV-1: div goes to 0 and the rotation offset rot increments, wrapping from LEN-1 to 0. LEN = CYCLE_HI-CYCLE_LO+1.
  - When cycle_en=0, both div and rot are held at 0.
- Effective index: if CYCLE_LO ≤ index ≤ CYCLE_HI, eff = CYCLE_LO + ((index-CYCLE_LO+rot) mod LEN); otherwise eff = index.
- Pipeline stage 1: on valid_in, register valid, pal_sel, eff (computed with the current rot), fade, and the flag (index==0).
- Pipeline stage 2: read entry [pal][eff]. Each channel becomes max(ch − fade, 0), saturating at 0, 4-bit. Register the result, transparent, and valid_out.
- Out-of-range pal_sel in a request: the result is BG_COLOR, and transparent follows index as usual.
- When valid_out=0: red/green/blue/transparent are 0 (blanking).

## Timing
- Reset values: valid_out=0, red/green/blue=0, transparent=0, rot=0, div=0, both pipeline stages invalid.
- Latency: exactly 2 cycles from valid_in to valid_out. Full throughput of one request per cycle, with no stalls and no back-pressure.
- Write/read collision: a stage-2 read of the entry being written in the same cycle returns the old value. The new value is visible to reads one cycle later.
- rot update vs request: a request sampled in the same cycle that rot increments uses the old rot.
- A frame_tick in the same cycle that cycle_en falls does not advance rot; the counters clear.
- An asynchronous Reset_n assertion mid-pipeline immediately drops valid_out and zeroes the colours. In-flight requests are lost, and the palette contents revert to BG_COLOR.

## Test plan
- Reset: hold Reset_n=0 and issue a request with pal 0, index 5 after release. Required: valid_out 2 cycles later with RGB = 9,9,F and transparent=0.
- Write/readback with fade: write pal 2 addr 3 = 12'hB32, then request pal 2, idx 3, fade 0. Required: B,3,2. Repeat with fade 4. Required: 7,0,0.
- Transparency and blanking: request idx 0 → transparent=1, colours still output. Drop valid_in → one cycle later all outputs are 0.
- Cycling: with cycle_en=1 and CYCLE_DIV=8, write entries 8..11 = 1,2,3,4 (hex in red). Send 8 frame_ticks. Required: request idx 8 → red=2. After 24 more ticks, idx 8 → red=1 (wrap). Drop cycle_en → red=1 after the next request.
- Collision: write pal 0 addr 6 = 12'hE92 in the same cycle a prior request for [0][6] is in stage 2. Required: that result = 9,9,F; the next request = E,9,2.
- Back-to-back: 16 consecutive requests, indices 0..15. Required: 16 consecutive valid_out cycles in order, starting 2 cycles after the first request.
